// File: rtl/multicycle_cu.sv
// Multi-cycle RV32I control unit: steps each instruction through fetch, decode,
// execute, memory and write-back, driving the datapath enables and selects.
//
// state  | meaning
// FETCH  | read instruction at PC, load IR and PC+4 once memory is ready
// DECODE | classify latched opcode, illegal opcodes go to TRAP
// EXEC   | ALU operation for the class; branches resolve and retire here
// MEM    | data access at ALU address, held until memory is ready
// WB     | register file write from ALU out or MDR
// TRAP   | illegal opcode seen, absorbing until reset
module multicycle_cu #(
    parameter int MEM_HANDSHAKE = 1,
    parameter int ENABLE_IALU   = 1,
    parameter int ALUOP_W       = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [31:0]        inst,
    input  logic               mem_ready,
    input  logic               branch_taken,
    output logic               pc_write,
    output logic               pc_src,
    output logic               ir_write,
    output logic               iord,
    output logic               mem_read,
    output logic               mem_write,
    output logic               reg_write,
    output logic               mem_to_reg,
    output logic [1:0]         alu_src_a,
    output logic [1:0]         alu_src_b,
    output logic [ALUOP_W-1:0] alu_op,
    output logic               retire,
    output logic               illegal,
    output logic [2:0]         state
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_TRAP   = 3'd5
    } state_t;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    state_t     state_q, state_d;
    logic [6:0] opcode_q;
    logic       ready;
    logic       is_r, is_i, is_load, is_store, is_branch, legal;
    logic       unused_inst;

    logic       pc_write_c, pc_src_c, ir_write_c, iord_c, mem_read_c, mem_write_c;
    logic       reg_write_c, mem_to_reg_c, retire_c, illegal_c;
    logic [1:0] alu_src_a_c, alu_src_b_c, alu_op_c;

    assign ready       = (MEM_HANDSHAKE != 0) ? mem_ready : 1'b1;
    assign unused_inst = ^inst[31:7];

    assign is_r      = (opcode_q == OP_R);
    assign is_i      = (opcode_q == OP_IMM) && (ENABLE_IALU != 0);
    assign is_load   = (opcode_q == OP_LOAD);
    assign is_store  = (opcode_q == OP_STORE);
    assign is_branch = (opcode_q == OP_BRANCH);
    assign legal     = is_r | is_i | is_load | is_store | is_branch;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_FETCH;
            opcode_q <= 7'b0000000;
        end else begin
            state_q <= state_d;
            if (ir_write_c) begin
                opcode_q <= inst[6:0];
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        pc_write_c   = 1'b0;
        pc_src_c     = 1'b0;
        ir_write_c   = 1'b0;
        iord_c       = 1'b0;
        mem_read_c   = 1'b0;
        mem_write_c  = 1'b0;
        reg_write_c  = 1'b0;
        mem_to_reg_c = 1'b0;
        retire_c     = 1'b0;
        illegal_c    = 1'b0;
        alu_src_a_c  = 2'b00;
        alu_src_b_c  = 2'b00;
        alu_op_c     = 2'b00;
        case (state_q)
            S_FETCH: begin
                mem_read_c  = 1'b1;
                alu_src_b_c = 2'b01;
                if (ready) begin
                    ir_write_c = 1'b1;
                    pc_write_c = 1'b1;
                    state_d    = S_DECODE;
                end
            end
            S_DECODE: begin
                state_d = legal ? S_EXEC : S_TRAP;
            end
            S_EXEC: begin
                alu_src_a_c = 2'b01;
                if (is_r) begin
                    alu_op_c = 2'b10;
                    state_d  = S_WB;
                end else if (is_i) begin
                    alu_src_b_c = 2'b10;
                    alu_op_c    = 2'b11;
                    state_d     = S_WB;
                end else if (is_load || is_store) begin
                    alu_src_b_c = 2'b10;
                    state_d     = S_MEM;
                end else begin
                    // Only branches reach this arm once DECODE has filtered opcodes
                    alu_op_c   = 2'b01;
                    pc_src_c   = 1'b1;
                    pc_write_c = branch_taken;
                    retire_c   = 1'b1;
                    state_d    = S_FETCH;
                end
            end
            S_MEM: begin
                iord_c      = 1'b1;
                mem_read_c  = is_load;
                mem_write_c = is_store;
                if (ready) begin
                    if (is_load) begin
                        state_d = S_WB;
                    end else begin
                        retire_c = 1'b1;
                        state_d  = S_FETCH;
                    end
                end
            end
            S_WB: begin
                reg_write_c  = 1'b1;
                mem_to_reg_c = is_load;
                retire_c     = 1'b1;
                state_d      = S_FETCH;
            end
            S_TRAP: begin
                illegal_c = 1'b1;
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase
    end

    // Reset masks every output so an abandoned instruction issues no partial write
    assign pc_write   = pc_write_c & ~rst;
    assign pc_src     = pc_src_c & ~rst;
    assign ir_write   = ir_write_c & ~rst;
    assign iord       = iord_c & ~rst;
    assign mem_read   = mem_read_c & ~rst;
    assign mem_write  = mem_write_c & ~rst;
    assign reg_write  = reg_write_c & ~rst;
    assign mem_to_reg = mem_to_reg_c & ~rst;
    assign retire     = retire_c & ~rst;
    assign illegal    = illegal_c & ~rst;
    assign alu_src_a  = rst ? 2'b00 : alu_src_a_c;
    assign alu_src_b  = rst ? 2'b00 : alu_src_b_c;
    assign alu_op     = rst ? '0 : ALUOP_W'(alu_op_c);
    assign state      = rst ? 3'd0 : state_q;

endmodule

// File: tb/tb_multicycle_cu.sv
// Bench for multicycle_cu: a driver issues instructions with random wait states
// and pushes the expected per-instruction profile; a monitor checks on retire/trap/reset.
module tb_multicycle_cu;

    logic        clk = 1'b0;
    logic        rst, mem_ready, branch_taken;
    logic [31:0] inst;
    logic        pc_write, pc_src, ir_write, iord, mem_read, mem_write;
    logic        reg_write, mem_to_reg, retire, illegal;
    logic [1:0]  alu_src_a, alu_src_b, alu_op;
    logic [2:0]  state;

    multicycle_cu #(.MEM_HANDSHAKE(1), .ENABLE_IALU(1), .ALUOP_W(2)) dut (
        .clk(clk), .rst(rst), .inst(inst), .mem_ready(mem_ready),
        .branch_taken(branch_taken), .pc_write(pc_write), .pc_src(pc_src),
        .ir_write(ir_write), .iord(iord), .mem_read(mem_read),
        .mem_write(mem_write), .reg_write(reg_write), .mem_to_reg(mem_to_reg),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
        .retire(retire), .illegal(illegal), .state(state)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // kind: 0 retires, 1 traps, 2 abandoned by reset
    typedef struct {
        int          kind;
        int          cycles;
        logic [62:0] trace;
        int          pcw, irw, mr, mw, rw;
        logic        m2r;
        logic [1:0]  op, a, b;
        logic        pcsrc;
    } exp_t;

    exp_t sb[$];

    // Classes: 0 R, 1 OP-IMM, 2 LOAD, 3 STORE, 4 BRANCH, 5 illegal
    localparam logic [31:0] BASE [5] = '{32'h002081B3, 32'h00508093, 32'h0000A183,
                                         32'h0030A023, 32'h00208463};

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [62:0] tr_push(input logic [62:0] t, input logic [2:0] s);
        return {t[59:0], s};
    endfunction

    function automatic bit is_legal(input logic [6:0] opc);
        return opc == 7'h33 || opc == 7'h13 || opc == 7'h03 || opc == 7'h23 || opc == 7'h63;
    endfunction

    // Expected profile built from the instruction's sequence of phases
    function automatic exp_t model(input int cls, input int wf, input int wm,
                                   input bit taken, input bit abort);
        exp_t e;
        e.kind = 0; e.cycles = 0; e.trace = '0;
        e.pcw = 1; e.irw = 1; e.mr = wf + 1; e.mw = 0; e.rw = 0;
        e.m2r = 1'b0; e.op = 2'd0; e.a = 2'd0; e.b = 2'd0; e.pcsrc = 1'b0;
        for (int i = 0; i <= wf; i++) begin
            e.trace = tr_push(e.trace, 3'd0); e.cycles++;
        end
        e.trace = tr_push(e.trace, 3'd1); e.cycles++;
        if (cls == 5) begin
            e.trace = tr_push(e.trace, 3'd5); e.cycles++;
            e.kind = 1;
            return e;
        end
        e.trace = tr_push(e.trace, 3'd2); e.cycles++;
        e.a = 2'd1;
        case (cls)
            0: begin e.op = 2'd2; e.b = 2'd0; end
            1: begin e.op = 2'd3; e.b = 2'd2; end
            2, 3: begin e.op = 2'd0; e.b = 2'd2; end
            default: begin e.op = 2'd1; e.b = 2'd0; e.pcsrc = 1'b1; e.pcw += int'(taken); end
        endcase
        if (abort) begin
            e.kind = 2;
            return e;
        end
        if (cls == 2 || cls == 3) begin
            for (int i = 0; i <= wm; i++) begin
                e.trace = tr_push(e.trace, 3'd3); e.cycles++;
            end
            if (cls == 2) e.mr += wm + 1;
            else e.mw = wm + 1;
        end
        if (cls <= 2) begin
            e.trace = tr_push(e.trace, 3'd4); e.cycles++;
            e.rw = 1;
            e.m2r = (cls == 2);
        end
        return e;
    endfunction

    function automatic logic rb();
        return logic'($urandom_range(1, 0));
    endfunction

    task automatic drive(input logic r, input logic [31:0] iw, input logic bt, input logic rs);
        mem_ready = r; inst = iw; branch_taken = bt; rst = rs;
        @(posedge clk);
        #1;
    endtask

    task automatic run(input int cls, input logic [31:0] iw, input int wf, input int wm,
                       input bit taken, input bit abort);
        sb.push_back(model(cls, wf, wm, taken, abort));
        for (int i = 0; i < wf; i++) drive(1'b0, $urandom, rb(), 1'b0);
        drive(1'b1, iw, rb(), 1'b0);
        drive(rb(), $urandom, rb(), 1'b0);
        if (cls == 5) begin
            repeat (10) drive(rb(), $urandom, rb(), 1'b0);
            drive(rb(), $urandom, rb(), 1'b1);
            return;
        end
        drive(rb(), $urandom, taken, 1'b0);
        if (cls == 2 || cls == 3) begin
            if (abort) begin
                drive(rb(), $urandom, rb(), 1'b1);
                return;
            end
            for (int i = 0; i < wm; i++) drive(1'b0, $urandom, rb(), 1'b0);
            drive(1'b1, $urandom, rb(), 1'b0);
        end
        if (cls <= 2) drive(rb(), $urandom, rb(), 1'b0);
    endtask

    // Monitor state
    int          obs_cycles = 0, obs_pcw = 0, obs_irw = 0, obs_mr = 0, obs_mw = 0, obs_rw = 0;
    logic [62:0] obs_trace = '0;
    logic        obs_m2r = 1'b0, obs_pcsrc = 1'b0, in_trap = 1'b0;
    logic [1:0]  obs_op = 2'd0, obs_a = 2'd0, obs_b = 2'd0;
    exp_t        em;

    task automatic clear_obs();
        obs_cycles = 0; obs_pcw = 0; obs_irw = 0; obs_mr = 0; obs_mw = 0; obs_rw = 0;
        obs_trace = '0; obs_m2r = 1'b0; obs_pcsrc = 1'b0;
        obs_op = 2'd0; obs_a = 2'd0; obs_b = 2'd0;
    endtask

    task automatic cmp_common(input exp_t e);
        chk("cycles", 64'(obs_cycles), 64'(e.cycles));
        chk("state_trace", 64'(obs_trace), 64'(e.trace));
        chk("pc_write_count", 64'(obs_pcw), 64'(e.pcw));
        chk("ir_write_count", 64'(obs_irw), 64'(e.irw));
        chk("mem_read_count", 64'(obs_mr), 64'(e.mr));
        chk("mem_write_count", 64'(obs_mw), 64'(e.mw));
        chk("reg_write_count", 64'(obs_rw), 64'(e.rw));
    endtask

    always @(negedge clk) begin
        if (rst) begin
            chk("reset_outputs_zero",
                64'({pc_write, pc_src, ir_write, iord, mem_read, mem_write, reg_write,
                     mem_to_reg, alu_src_a, alu_src_b, alu_op, retire, illegal, state}), 64'd0);
            if (sb.size() > 0 && sb[0].kind == 2) begin
                em = sb.pop_front();
                cmp_common(em);
            end
            clear_obs();
            in_trap = 1'b0;
        end else begin
            obs_cycles++;
            obs_trace = tr_push(obs_trace, state);
            obs_pcw += int'(pc_write);
            obs_irw += int'(ir_write);
            obs_mr  += int'(mem_read);
            obs_mw  += int'(mem_write);
            obs_rw  += int'(reg_write);
            if (reg_write) obs_m2r = mem_to_reg;
            if (state == 3'd2) begin
                obs_op = alu_op; obs_a = alu_src_a; obs_b = alu_src_b; obs_pcsrc = pc_src;
            end
            chk("strobe_retire_rules",
                64'((mem_read && mem_write) ||
                    (retire && (state == 3'd0 || state == 3'd1 || state == 3'd5))), 64'd0);
            if (in_trap) begin
                chk("trap_hold",
                    64'({illegal, state, pc_write, ir_write, mem_read, mem_write, reg_write, retire}),
                    64'({1'b1, 3'd5, 6'b0}));
            end else if (retire || illegal) begin
                if (sb.size() == 0) begin
                    chk("unexpected_event", 64'({retire, illegal}), 64'd0);
                end else begin
                    em = sb.pop_front();
                    chk("event_kind", 64'(illegal ? 1 : 0), 64'(em.kind));
                    cmp_common(em);
                    if (em.kind == 0) begin
                        chk("exec_alu_op", 64'(obs_op), 64'(em.op));
                        chk("exec_alu_src_a", 64'(obs_a), 64'(em.a));
                        chk("exec_alu_src_b", 64'(obs_b), 64'(em.b));
                        chk("exec_pc_src", 64'(obs_pcsrc), 64'(em.pcsrc));
                        if (em.rw != 0) chk("wb_mem_to_reg", 64'(obs_m2r), 64'(em.m2r));
                    end
                end
                clear_obs();
                in_trap = illegal;
            end else if (obs_cycles > 30) begin
                chk("event_timeout", 64'(obs_cycles), 64'd30);
                clear_obs();
            end
        end
    end

    initial begin
        logic [31:0] r, iw;
        int          cls, wf, wm;
        bit          taken, abort;
        rst = 1'b1; mem_ready = 1'b0; branch_taken = 1'b0; inst = '0;
        #1;
        repeat (3) drive(1'b0, 32'h0, 1'b0, 1'b1);

        run(0, 32'h002081B3, 0, 0, 1'b0, 1'b0);
        run(2, 32'h0000A183, 0, 2, 1'b0, 1'b0);
        run(3, 32'h0030A023, 0, 0, 1'b0, 1'b0);
        run(4, 32'h00208463, 0, 0, 1'b1, 1'b0);
        run(4, 32'h00208463, 0, 0, 1'b0, 1'b0);
        run(5, 32'h0000007F, 0, 0, 1'b0, 1'b0);
        run(3, 32'h0030A023, 1, 0, 1'b0, 1'b1);
        run(1, 32'h00508093, 2, 0, 1'b0, 1'b0);
        run(5, 32'h00A00001, 0, 0, 1'b0, 1'b0);

        for (int n = 0; n < 60; n++) begin
            cls   = int'($urandom_range(5, 0));
            wf    = int'($urandom_range(3, 0));
            wm    = int'($urandom_range(3, 0));
            taken = bit'($urandom_range(1, 0));
            abort = (cls == 3) && ($urandom_range(4, 0) == 0);
            r     = $urandom;
            if (cls == 5) begin
                iw = r;
                while (is_legal(iw[6:0])) begin
                    r  = $urandom;
                    iw = r;
                end
            end else begin
                iw = BASE[cls];
                iw = {r[31:7], iw[6:0]};
            end
            run(cls, iw, wf, wm, taken, abort);
        end

        repeat (2) drive(1'b0, 32'h0, 1'b0, 1'b1);
        chk("scoreboard_drained", 64'(sb.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
